dcache_miss_ctrl: RTL and testbench
===================================

// Module: dcache_miss_ctrl
// PURPOSE
//  Sequencer between the load/store units, the 4-way Dcache array and the single memory bus.
//  Serves one request at a time: load/store hits complete in the Dcache, and misses run a
//  victim writeback and/or line fetch on the memory bus.
//  Write-back, write-allocate policy. Lines are 64 bits, so a store miss allocates without a fetch.
// PARAMETERS
//  MEM_TAG_W  4   width of memory transaction tag; tag 0 = request rejected
//  TAG_W      --  width of SASS_ADDR.tag (from `NUM_TAG_BITS)
// PORTS
//  clock            in   1      system clock
//  reset            in   1      asynchronous, active-high reset
//  ld_req           in   1      load request; held high until ld_done
//  ld_addr          in   SASS_ADDR  load address
//  ld_done          out  1      1-cycle pulse: ld_data valid
//  ld_data          out  64     load result
//  st_req           in   1      retired store request; held until st_done
//  st_addr          in   SASS_ADDR  store address
//  st_data          in   64     store data
//  st_done          out  1      1-cycle pulse: store written into cache
//  rd1_addr/rd1_search  out  SASS_ADDR/1  Dcache read port drive
//  rd1_hit_out, rd1_data_out  in  1/64  Dcache read result
//  wr1_addr, wr1_search, wr1_en, wr1_from_mem  out  SASS_ADDR/1/1/1  Dcache write port
//  wr1_data, wr1_dirty, wr1_valid  out  64/1/1  Dcache write payload
//  wr1_hit_out      in   1      Dcache write-port tag hit
//  evicted_valid_out, evicted_dirty_out, evicted_addr_out, evicted_data_out  in  1/1/SASS_ADDR/64  LRU victim
//  proc2mem_command out  2      BUS_NONE/BUS_LOAD/BUS_STORE
//  proc2mem_addr    out  64     bus address, {tag,set_index,3'b000}
//  proc2mem_data    out  64     writeback data
//  mem2proc_response in  MEM_TAG_W  accepted tag; 0 = reject, retry next cycle
//  mem2proc_data    in   64     returned line
//  mem2proc_tag     in   MEM_TAG_W  tag of returned data
// BEHAVIOUR
//  Reset (async): state=IDLE. ld_done=st_done=0, ld_data=0. All cache strobes (wr1_en, searches) = 0.
//   proc2mem_command=BUS_NONE. Saved request and mem tag cleared.
//  States: IDLE, WB_REQ, LD_REQ, LD_WAIT, FILL, RESP.
//  IDLE: st_req has priority over ld_req. Request is latched and presented on rd1 and wr1 (search=1).
//   Load hit: ld_data<=rd1_data_out, ld_done=1 next cycle; stay IDLE.
//   Store hit: wr1_en=1, wr1_dirty=1, wr1_valid=1, wr1_from_mem=0 same cycle; st_done=1 next cycle.
//   Miss, victim valid&dirty: latch victim addr/data -> WB_REQ.
//   Miss otherwise: load -> LD_REQ; store -> FILL.
//  WB_REQ: drive BUS_STORE with latched victim. Response!=0 -> (load ? LD_REQ : FILL); 0 -> stay.
//  LD_REQ: drive BUS_LOAD with ld_addr. Response!=0 -> save tag, go LD_WAIT; 0 -> retry.
//  LD_WAIT: bus=BUS_NONE. mem2proc_tag==saved tag && !=0 -> latch mem2proc_data -> FILL.
//   All other tags are ignored.
//  FILL: one cycle. wr1_en=1, wr1_from_mem=1 (advances LRU), wr1_valid=1.
//   Load: data=fetched, dirty=0. Store: data=st_data, dirty=1. -> RESP.
//  RESP: pulse ld_done (ld_data=fetched) or st_done; -> IDLE. A new request is not accepted in RESP.
//  Only one outstanding miss. Requests arriving while not IDLE wait (held by requester).
//  A load and a store to the same line are serialised by the store-first priority.
//  Done pulses are exactly 1 cycle. The requester drops req the cycle after done.
//   Controller ignores req in the cycle done is high.
//  Reset mid-miss: abandon. A late mem2proc_tag is ignored because the saved tag is cleared.
//  Victim address is taken from evicted_addr_out in the IDLE decision cycle, before FILL changes the LRU.
// TESTING
//  1 ld_req 0x100 after reset -> miss, BUS_LOAD 0x100; resp=3, 4 cycles later tag=3 data=D
//    -> FILL, ld_done with D; repeat ld 0x100 -> ld_done next cycle.
//  2 st_req 0x100 data=0xAA on resident line -> wr1_en dirty=1, st_done next cycle, no bus activity.
//  3 Fill 4 ways of one set, dirty way is LRU, ld to new tag -> BUS_STORE of victim data first,
//    then BUS_LOAD, then fill.
//  4 mem2proc_response=0 for 3 cycles in LD_REQ -> BUS_LOAD reissued each cycle;
//    mismatched tag 5 in LD_WAIT ignored.
//  5 ld_req and st_req same cycle -> st_done precedes ld_done; ld held until served.
//  6 reset asserted in LD_WAIT, then tag returns -> no cache write, no ld_done, state IDLE.

Source files
------------

// File: rtl/dcache_miss_ctrl.sv
// Dcache miss sequencer: serves one load/store at a time, completing hits in the cache
// and running victim writeback / line fetch on the memory bus for misses.
package dcache_miss_ctrl_pkg;
  localparam int NUM_TAG_BITS = 8;
  localparam int SET_W        = 4;

  typedef struct packed {
    logic [NUM_TAG_BITS-1:0] tag;
    logic [SET_W-1:0]        set_index;
    logic [2:0]              offset;
  } sass_addr_t;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_t;
endpackage

// Handshake: ld_req/st_req are held by the requester until the matching 1-cycle done
// pulse; the request is ignored while done is high and dropped the following cycle.
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int MEM_TAG_W = 4,
  parameter int TAG_W     = NUM_TAG_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ld_req,
  input  sass_addr_t           ld_addr,
  output logic                 ld_done,
  output logic [63:0]          ld_data,
  input  logic                 st_req,
  input  sass_addr_t           st_addr,
  input  logic [63:0]          st_data,
  output logic                 st_done,
  output sass_addr_t           rd1_addr,
  output logic                 rd1_search,
  input  logic                 rd1_hit_out,
  input  logic [63:0]          rd1_data_out,
  output sass_addr_t           wr1_addr,
  output logic                 wr1_search,
  output logic                 wr1_en,
  output logic                 wr1_from_mem,
  output logic [63:0]          wr1_data,
  output logic                 wr1_dirty,
  output logic                 wr1_valid,
  input  logic                 wr1_hit_out,
  input  logic                 evicted_valid_out,
  input  logic                 evicted_dirty_out,
  input  sass_addr_t           evicted_addr_out,
  input  logic [63:0]          evicted_data_out,
  output bus_cmd_t             proc2mem_command,
  output logic [63:0]          proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_response,
  input  logic [63:0]          mem2proc_data,
  input  logic [MEM_TAG_W-1:0] mem2proc_tag,
  output logic [2:0]           state_dbg
);

  localparam int LINE_W = TAG_W + SET_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    LD_REQ  = 3'd2,
    LD_WAIT = 3'd3,
    FILL    = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t               state, state_next;
  logic                 req_is_st;
  sass_addr_t           req_addr;
  logic [63:0]          req_data;
  sass_addr_t           victim_addr;
  logic [63:0]          victim_data;
  logic [MEM_TAG_W-1:0] mem_tag;
  logic [63:0]          fill_data;

  logic       accept;
  logic       pick_st;
  logic       hit;
  logic       victim_dirty;
  logic       tag_match;
  sass_addr_t sel_addr;

  function automatic logic [63:0] line_addr(input sass_addr_t a);
    logic [LINE_W-1:0] line;
    line = {a.tag[TAG_W-1:0], a.set_index};
    return {{(64-LINE_W-3){1'b0}}, line, 3'b000};
  endfunction

  assign accept       = (state == IDLE) && (st_req || ld_req) && !ld_done && !st_done;
  assign pick_st      = st_req;
  assign sel_addr     = pick_st ? st_addr : ld_addr;
  assign hit          = pick_st ? wr1_hit_out : rd1_hit_out;
  assign victim_dirty = evicted_valid_out && evicted_dirty_out;
  assign tag_match    = (mem_tag != '0) && (mem2proc_tag == mem_tag);
  assign state_dbg    = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    rd1_addr         = req_addr;
    rd1_search       = 1'b0;
    wr1_addr         = req_addr;
    wr1_search       = 1'b0;
    wr1_en           = 1'b0;
    wr1_from_mem     = 1'b0;
    wr1_data         = req_data;
    wr1_dirty        = 1'b0;
    wr1_valid        = 1'b0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          rd1_addr   = sel_addr;
          rd1_search = 1'b1;
          wr1_addr   = sel_addr;
          wr1_search = 1'b1;
          wr1_data   = st_data;
          if (pick_st && wr1_hit_out) begin
            wr1_en    = 1'b1;
            wr1_dirty = 1'b1;
            wr1_valid = 1'b1;
          end
          if (!hit) begin
            if (victim_dirty) state_next = WB_REQ;
            else              state_next = pick_st ? FILL : LD_REQ;
          end
        end
      end
      WB_REQ: begin
        proc2mem_command = BUS_STORE;
        proc2mem_addr    = line_addr(victim_addr);
        proc2mem_data    = victim_data;
        if (mem2proc_response != '0) state_next = req_is_st ? FILL : LD_REQ;
      end
      LD_REQ: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = line_addr(req_addr);
        if (mem2proc_response != '0) state_next = LD_WAIT;
      end
      LD_WAIT: begin
        if (tag_match) state_next = FILL;
      end
      FILL: begin
        // from_mem makes the array write the LRU way and advance LRU
        wr1_en       = 1'b1;
        wr1_from_mem = 1'b1;
        wr1_valid    = 1'b1;
        wr1_dirty    = req_is_st;
        wr1_data     = req_is_st ? req_data : fill_data;
        state_next   = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_is_st   <= 1'b0;
      req_addr    <= '0;
      req_data    <= '0;
      victim_addr <= '0;
      victim_data <= '0;
      mem_tag     <= '0;
      fill_data   <= '0;
      ld_done     <= 1'b0;
      st_done     <= 1'b0;
      ld_data     <= '0;
    end else begin
      ld_done <= 1'b0;
      st_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            req_is_st <= pick_st;
            req_addr  <= sel_addr;
            req_data  <= st_data;
            if (hit) begin
              if (pick_st) begin
                st_done <= 1'b1;
              end else begin
                ld_done <= 1'b1;
                ld_data <= rd1_data_out;
              end
            end else if (victim_dirty) begin
              // victim must be captured now, before the fill moves LRU
              victim_addr <= evicted_addr_out;
              victim_data <= evicted_data_out;
            end
          end
        end
        LD_REQ: begin
          if (mem2proc_response != '0) mem_tag <= mem2proc_response;
        end
        LD_WAIT: begin
          if (tag_match) begin
            fill_data <= mem2proc_data;
            mem_tag   <= '0;
          end
        end
        FILL: begin
          if (req_is_st) begin
            st_done <= 1'b1;
          end else begin
            ld_done <= 1'b1;
            ld_data <= fill_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: the cache array and memory bus are driven by hand
// per scenario, and every observed output is compared with a hand-computed value.
module tb_dcache_miss_ctrl;
  import dcache_miss_ctrl_pkg::*;

  logic        clock;
  logic        reset;
  logic        ld_req;
  sass_addr_t  ld_addr;
  logic        ld_done;
  logic [63:0] ld_data;
  logic        st_req;
  sass_addr_t  st_addr;
  logic [63:0] st_data;
  logic        st_done;
  sass_addr_t  rd1_addr;
  logic        rd1_search;
  logic        rd1_hit_out;
  logic [63:0] rd1_data_out;
  sass_addr_t  wr1_addr;
  logic        wr1_search;
  logic        wr1_en;
  logic        wr1_from_mem;
  logic [63:0] wr1_data;
  logic        wr1_dirty;
  logic        wr1_valid;
  logic        wr1_hit_out;
  logic        evicted_valid_out;
  logic        evicted_dirty_out;
  sass_addr_t  evicted_addr_out;
  logic [63:0] evicted_data_out;
  bus_cmd_t    proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_WB = 3'd1, S_LDREQ = 3'd2,
                         S_WAIT = 3'd3, S_FILL = 3'd4, S_RESP = 3'd5;
  localparam logic [63:0] D_A = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] D_V = 64'h7777_0000_1111_2222;
  localparam logic [63:0] D_E = 64'hE0E1_E2E3_E4E5_E6E7;
  localparam logic [63:0] D_F = 64'hF00D_F00D_F00D_F00D;

  dcache_miss_ctrl #(.MEM_TAG_W(4)) dut (
    .clock(clock), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_done(st_done),
    .rd1_addr(rd1_addr), .rd1_search(rd1_search),
    .rd1_hit_out(rd1_hit_out), .rd1_data_out(rd1_data_out),
    .wr1_addr(wr1_addr), .wr1_search(wr1_search), .wr1_en(wr1_en),
    .wr1_from_mem(wr1_from_mem), .wr1_data(wr1_data), .wr1_dirty(wr1_dirty),
    .wr1_valid(wr1_valid), .wr1_hit_out(wr1_hit_out),
    .evicted_valid_out(evicted_valid_out), .evicted_dirty_out(evicted_dirty_out),
    .evicted_addr_out(evicted_addr_out), .evicted_data_out(evicted_data_out),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
    .state_dbg(state_dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge; inputs are driven and outputs sampled here
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ld_req = 0; ld_addr = '0; st_req = 0; st_addr = '0; st_data = '0;
    rd1_hit_out = 0; rd1_data_out = '0; wr1_hit_out = 0;
    evicted_valid_out = 0; evicted_dirty_out = 0; evicted_addr_out = '0; evicted_data_out = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    settle();
    check("rst_state", 64'(state_dbg), 64'(S_IDLE));
    check("rst_ld_done", 64'(ld_done), 64'd0);
    check("rst_st_done", 64'(st_done), 64'd0);
    check("rst_ld_data", ld_data, 64'd0);
    check("rst_cmd", 64'(proc2mem_command), 64'(BUS_NONE));
    check("rst_wr1_en", 64'(wr1_en), 64'd0);
    check("rst_rd1_search", 64'(rd1_search), 64'd0);

    // 1: cold load miss, fill, then the same load hits
    ld_req = 1; ld_addr = sass_addr_t'(15'h100);
    settle();
    check("t1_rd1_search", 64'(rd1_search), 64'd1);
    check("t1_rd1_addr", 64'(rd1_addr), 64'h100);
    tick();
    check("t1_state_ldreq", 64'(state_dbg), 64'(S_LDREQ));
    check("t1_cmd_load", 64'(proc2mem_command), 64'(BUS_LOAD));
    check("t1_bus_addr", proc2mem_addr, 64'h100);
    mem2proc_response = 4'd3;
    tick();
    mem2proc_response = '0;
    check("t1_state_wait", 64'(state_dbg), 64'(S_WAIT));
    check("t1_cmd_none", 64'(proc2mem_command), 64'(BUS_NONE));
    tick(); tick(); tick();
    check("t1_still_wait", 64'(state_dbg), 64'(S_WAIT));
    mem2proc_tag = 4'd3; mem2proc_data = D_A;
    tick();
    mem2proc_tag = '0; mem2proc_data = '0;
    check("t1_fill_state", 64'(state_dbg), 64'(S_FILL));
    check("t1_fill_en", 64'(wr1_en), 64'd1);
    check("t1_fill_from_mem", 64'(wr1_from_mem), 64'd1);
    check("t1_fill_valid", 64'(wr1_valid), 64'd1);
    check("t1_fill_dirty", 64'(wr1_dirty), 64'd0);
    check("t1_fill_data", wr1_data, D_A);
    check("t1_fill_addr", 64'(wr1_addr), 64'h100);
    tick();
    check("t1_resp_done", 64'(ld_done), 64'd1);
    check("t1_resp_data", ld_data, D_A);
    tick();
    ld_req = 0;
    check("t1_done_pulse", 64'(ld_done), 64'd0);
    check("t1_back_idle", 64'(state_dbg), 64'(S_IDLE));
    ld_req = 1; ld_addr = sass_addr_t'(15'h100); rd1_hit_out = 1; rd1_data_out = D_A;
    settle();
    check("t1_hit_no_bus", 64'(proc2mem_command), 64'(BUS_NONE));
    tick();
    check("t1_hit_done", 64'(ld_done), 64'd1);
    check("t1_hit_data", ld_data, D_A);
    check("t1_hit_idle", 64'(state_dbg), 64'(S_IDLE));
    tick();
    ld_req = 0; rd1_hit_out = 0;
    check("t1_hit_once", 64'(ld_done), 64'd0);

    // 2: store hit on resident line
    st_req = 1; st_addr = sass_addr_t'(15'h100); st_data = 64'hAA; wr1_hit_out = 1;
    settle();
    check("t2_wr_en", 64'(wr1_en), 64'd1);
    check("t2_wr_dirty", 64'(wr1_dirty), 64'd1);
    check("t2_wr_valid", 64'(wr1_valid), 64'd1);
    check("t2_wr_from_mem", 64'(wr1_from_mem), 64'd0);
    check("t2_wr_data", wr1_data, 64'hAA);
    check("t2_no_bus", 64'(proc2mem_command), 64'(BUS_NONE));
    tick();
    check("t2_st_done", 64'(st_done), 64'd1);
    check("t2_ignored_wr", 64'(wr1_en), 64'd0);
    tick();
    st_req = 0; wr1_hit_out = 0;
    check("t2_done_once", 64'(st_done), 64'd0);

    // 3: load miss with dirty LRU victim: writeback, then fetch, then fill
    ld_req = 1; ld_addr = sass_addr_t'(15'h180);
    evicted_valid_out = 1; evicted_dirty_out = 1;
    evicted_addr_out = sass_addr_t'(15'h200); evicted_data_out = D_V;
    tick();
    evicted_valid_out = 0; evicted_dirty_out = 0;
    evicted_addr_out = sass_addr_t'(15'h7FF8); evicted_data_out = '1;
    check("t3_state_wb", 64'(state_dbg), 64'(S_WB));
    check("t3_cmd_store", 64'(proc2mem_command), 64'(BUS_STORE));
    check("t3_wb_addr", proc2mem_addr, 64'h200);
    check("t3_wb_data", proc2mem_data, D_V);
    tick();
    check("t3_wb_retry", 64'(state_dbg), 64'(S_WB));
    mem2proc_response = 4'd1;
    tick();
    mem2proc_response = '0;
    check("t3_then_load", 64'(proc2mem_command), 64'(BUS_LOAD));
    check("t3_load_addr", proc2mem_addr, 64'h180);
    mem2proc_response = 4'd2;
    tick();
    mem2proc_response = '0;
    mem2proc_tag = 4'd2; mem2proc_data = D_E;
    tick();
    mem2proc_tag = '0;
    check("t3_fill_data", wr1_data, D_E);
    check("t3_fill_dirty", 64'(wr1_dirty), 64'd0);
    tick();
    check("t3_ld_done", 64'(ld_done), 64'd1);
    check("t3_ld_data", ld_data, D_E);
    tick();
    ld_req = 0;

    // 4: bus rejects three times, then a foreign tag is ignored
    ld_req = 1; ld_addr = sass_addr_t'(15'h308);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t4_reissue_cmd", 64'(proc2mem_command), 64'(BUS_LOAD));
      check("t4_reissue_addr", proc2mem_addr, 64'h308);
      tick();
    end
    check("t4_still_ldreq", 64'(state_dbg), 64'(S_LDREQ));
    mem2proc_response = 4'd7;
    tick();
    mem2proc_response = '0;
    mem2proc_tag = 4'd5; mem2proc_data = 64'hBAD;
    tick();
    check("t4_tag5_ignored", 64'(state_dbg), 64'(S_WAIT));
    check("t4_tag5_no_write", 64'(wr1_en), 64'd0);
    mem2proc_tag = 4'd7; mem2proc_data = D_F;
    tick();
    mem2proc_tag = '0;
    check("t4_fill_data", wr1_data, D_F);
    tick();
    check("t4_ld_data", ld_data, D_F);
    tick();
    ld_req = 0;

    // 5: simultaneous requests, store served first
    st_req = 1; st_addr = sass_addr_t'(15'h100); st_data = 64'h55; wr1_hit_out = 1;
    ld_req = 1; ld_addr = sass_addr_t'(15'h108); rd1_hit_out = 1; rd1_data_out = 64'h1234;
    settle();
    check("t5_store_first", 64'(rd1_addr), 64'h100);
    check("t5_store_wr", 64'(wr1_en), 64'd1);
    tick();
    check("t5_st_done", 64'(st_done), 64'd1);
    check("t5_no_ld_yet", 64'(ld_done), 64'd0);
    tick();
    st_req = 0; wr1_hit_out = 0;
    settle();
    check("t5_load_next", 64'(rd1_addr), 64'h108);
    tick();
    check("t5_ld_done", 64'(ld_done), 64'd1);
    check("t5_ld_data", ld_data, 64'h1234);
    tick();
    ld_req = 0; rd1_hit_out = 0;

    // 6: reset during LD_WAIT abandons the miss
    ld_req = 1; ld_addr = sass_addr_t'(15'h400);
    tick();
    mem2proc_response = 4'd4;
    tick();
    mem2proc_response = '0;
    check("t6_in_wait", 64'(state_dbg), 64'(S_WAIT));
    reset = 1; ld_req = 0;
    settle();
    check("t6_rst_idle", 64'(state_dbg), 64'(S_IDLE));
    tick();
    reset = 0;
    mem2proc_tag = 4'd4; mem2proc_data = 64'hCAFE;
    tick();
    mem2proc_tag = '0;
    check("t6_late_state", 64'(state_dbg), 64'(S_IDLE));
    check("t6_late_no_wr", 64'(wr1_en), 64'd0);
    check("t6_late_no_done", 64'(ld_done), 64'd0);
    tick();
    check("t6_still_no_done", 64'(ld_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
